// File: rtl/nib_fetch.sv
// Instruction fetch/decode front end: splits ROM bytes into opcode/operand,
// assembles two-byte jump targets and drives the PC load interface.
// Optional illegal-opcode trap: define NIB_FETCH_ILLEGAL_TRAP_EN.
module nib_fetch #(
    parameter logic [3:0] JC_OP  = 4'hA,
    parameter logic [3:0] JNC_OP = 4'hB,
    parameter logic [3:0] JZ_OP  = 4'hC,
    parameter logic [3:0] JNZ_OP = 4'hD,
    parameter logic [3:0] JMP_OP = 4'hE
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic        phase,
    input  logic [7:0]  prog_byte,
    input  logic        flag_c,
    input  logic        flag_z,
    output logic [3:0]  instr,
    output logic [3:0]  oprnd,
    output logic        instr_valid,
    output logic        jump_en,
    output logic [11:0] jump_addr,
    output logic        halted
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        JUMP_LO = 2'd1
`ifdef NIB_FETCH_ILLEGAL_TRAP_EN
        ,
        HALT    = 2'd2
`endif
    } state_t;

    localparam int N_JUMP = 5;
    // Entry order must match the condition vector built below.
    localparam logic [N_JUMP*4-1:0] JUMP_OPS = {JMP_OP, JNZ_OP, JZ_OP, JNC_OP, JC_OP};

    state_t      state_reg, state_next;
    logic [3:0]  instr_reg, instr_next;
    logic [3:0]  oprnd_reg, oprnd_next;
    logic        valid_reg, valid_next;
    logic        jump_en_reg, jump_en_next;
    logic [11:0] jump_addr_reg, jump_addr_next;
    logic [3:0]  hi_reg, hi_next;
    logic [3:0]  op_reg, op_next;

    logic [N_JUMP-1:0] fetch_hit;
    logic [N_JUMP-1:0] taken_hit;
    logic [N_JUMP-1:0] cond_vec;
    logic              is_jump;
    logic              jump_taken;
    logic [11:0]       target;

    assign cond_vec   = {1'b1, ~flag_z, flag_z, ~flag_c, flag_c};
    assign target     = {hi_reg, prog_byte};

    generate
        for (genvar gi = 0; gi < N_JUMP; gi++) begin : g_jump_dec
            assign fetch_hit[gi] = (prog_byte[7:4] == JUMP_OPS[gi*4 +: 4]);
            assign taken_hit[gi] = (op_reg == JUMP_OPS[gi*4 +: 4]) && cond_vec[gi];
        end
    endgenerate

    assign is_jump    = |fetch_hit;
    assign jump_taken = |taken_hit;

`ifdef NIB_FETCH_ILLEGAL_TRAP_EN
    localparam logic [3:0] ILLEGAL_OP = 4'hF;
    // Shadow of the PC address of the byte presented at each sample edge.
    logic [11:0] pc_shadow_reg, pc_shadow_next;
    logic        halted_reg, halted_next;
`endif

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_reg     <= FETCH;
            instr_reg     <= 4'h0;
            oprnd_reg     <= 4'h0;
            valid_reg     <= 1'b0;
            jump_en_reg   <= 1'b0;
            jump_addr_reg <= 12'h000;
            hi_reg        <= 4'h0;
            op_reg        <= 4'h0;
`ifdef NIB_FETCH_ILLEGAL_TRAP_EN
            pc_shadow_reg <= 12'h000;
            halted_reg    <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            instr_reg     <= instr_next;
            oprnd_reg     <= oprnd_next;
            valid_reg     <= valid_next;
            jump_en_reg   <= jump_en_next;
            jump_addr_reg <= jump_addr_next;
            hi_reg        <= hi_next;
            op_reg        <= op_next;
`ifdef NIB_FETCH_ILLEGAL_TRAP_EN
            pc_shadow_reg <= pc_shadow_next;
            halted_reg    <= halted_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        instr_next     = instr_reg;
        oprnd_next     = oprnd_reg;
        valid_next     = 1'b0;
        jump_en_next   = jump_en_reg;
        jump_addr_next = jump_addr_reg;
        hi_next        = hi_reg;
        op_next        = op_reg;
`ifdef NIB_FETCH_ILLEGAL_TRAP_EN
        pc_shadow_next = pc_shadow_reg;
        halted_next    = halted_reg;
`endif
        // Only sample edges (phase high) advance anything; prog_byte is settled then.
        if (phase) begin
`ifdef NIB_FETCH_ILLEGAL_TRAP_EN
            pc_shadow_next = pc_shadow_reg + 12'd1;
`endif
            case (state_reg)
                FETCH: begin
                    jump_en_next = 1'b0;
                    if (is_jump) begin
                        hi_next    = prog_byte[3:0];
                        op_next    = prog_byte[7:4];
                        state_next = JUMP_LO;
                    end
`ifdef NIB_FETCH_ILLEGAL_TRAP_EN
                    else if (prog_byte[7:4] == ILLEGAL_OP) begin
                        state_next     = HALT;
                        halted_next    = 1'b1;
                        jump_en_next   = 1'b1;
                        jump_addr_next = pc_shadow_reg;
                    end
`endif
                    else begin
                        instr_next = prog_byte[7:4];
                        oprnd_next = prog_byte[3:0];
                        valid_next = 1'b1;
                    end
                end
                JUMP_LO: begin
                    state_next   = FETCH;
                    jump_en_next = jump_taken;
                    if (jump_taken) begin
                        jump_addr_next = target;
`ifdef NIB_FETCH_ILLEGAL_TRAP_EN
                        pc_shadow_next = target;
`endif
                    end
                end
`ifdef NIB_FETCH_ILLEGAL_TRAP_EN
                HALT: begin
                    // PC spins on the trapped address until reset.
                    pc_shadow_next = pc_shadow_reg;
                end
`endif
                default: state_next = FETCH;
            endcase
        end
    end

    assign instr       = instr_reg;
    assign oprnd       = oprnd_reg;
    assign instr_valid = valid_reg;
    assign jump_en     = jump_en_reg;
    assign jump_addr   = jump_addr_reg;
`ifdef NIB_FETCH_ILLEGAL_TRAP_EN
    assign halted      = halted_reg;
`else
    assign halted      = 1'b0;
`endif

endmodule

// File: tb/tb_nib_fetch.sv
// Bench for nib_fetch: directed vector table, reset/phase corner sequences,
// and random ROM programs run through a PC model and a behavioural reference.
module tb_nib_fetch;

    logic        clk = 1'b0;
    logic        Rst = 1'b1;
    logic        phase = 1'b0;
    logic [7:0]  prog_byte = 8'h00;
    logic        flag_c = 1'b0;
    logic        flag_z = 1'b0;
    logic [3:0]  instr;
    logic [3:0]  oprnd;
    logic        instr_valid;
    logic        jump_en;
    logic [11:0] jump_addr;
    logic        halted;

    nib_fetch dut (
        .clk(clk), .Rst(Rst), .phase(phase), .prog_byte(prog_byte),
        .flag_c(flag_c), .flag_z(flag_z), .instr(instr), .oprnd(oprnd),
        .instr_valid(instr_valid), .jump_en(jump_en), .jump_addr(jump_addr),
        .halted(halted)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    // System PC (follows the DUT's load interface, as the real PC would).
    logic [11:0] sys_pc = 12'h000;
    logic        sys_started = 1'b0;
    logic [7:0]  rom [4096];

    // Reference model state.
    logic        m_have_hi, m_halted, m_started;
    logic [3:0]  m_hi, m_op, m_instr, m_oprnd;
    logic        m_valid, m_jen;
    logic [11:0] m_jaddr, m_pc;

    typedef struct {
        logic [7:0]  b;
        logic        fc;
        logic        fz;
        logic        ev;
        logic [3:0]  ei;
        logic [3:0]  eo;
        logic        ej;
        logic [11:0] ea;
        logic [11:0] ep;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (pc=%h)", name, act, exp, sys_pc);
    endtask

    function automatic logic is_jump_op(input logic [3:0] op);
        return op inside {4'hA, 4'hB, 4'hC, 4'hD, 4'hE};
    endfunction

    function automatic logic cond_met(input logic [3:0] op, input logic c, input logic z);
        case (op)
            4'hA: return c;
            4'hB: return !c;
            4'hC: return z;
            4'hD: return !z;
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_reset();
        m_have_hi = 0; m_halted = 0; m_started = 0;
        m_hi = 0; m_op = 0; m_instr = 0; m_oprnd = 0;
        m_valid = 0; m_jen = 0; m_jaddr = 0; m_pc = 0;
    endtask

    task automatic model_step(input logic [7:0] b, input logic c, input logic z);
        if (m_started) m_pc = m_jen ? m_jaddr : m_pc + 12'd1;
        else m_started = 1;
        m_valid = 0;
        if (m_halted) return;
        if (m_have_hi) begin
            m_jen = cond_met(m_op, c, z);
            if (m_jen) m_jaddr = {m_hi, b};
            m_have_hi = 0;
        end else begin
            m_jen = 0;
            if (is_jump_op(b[7:4])) begin
                m_have_hi = 1; m_hi = b[3:0]; m_op = b[7:4];
            end
`ifdef NIB_FETCH_ILLEGAL_TRAP_EN
            else if (b[7:4] == 4'hF) begin
                m_halted = 1; m_jen = 1; m_jaddr = m_pc;
            end
`endif
            else begin
                m_instr = b[7:4]; m_oprnd = b[3:0]; m_valid = 1;
            end
        end
    endtask

    task automatic cmp_model();
        chk("instr_valid", 12'(instr_valid), 12'(m_valid));
        chk("instr", 12'(instr), 12'(m_instr));
        chk("oprnd", 12'(oprnd), 12'(m_oprnd));
        chk("jump_en", 12'(jump_en), 12'(m_jen));
        chk("jump_addr", jump_addr, m_jaddr);
        chk("halted", 12'(halted), 12'(m_halted));
        chk("pc", sys_pc, m_pc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        Rst = 1; phase = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_instr", 12'(instr), 12'h0);
        chk("rst_oprnd", 12'(oprnd), 12'h0);
        chk("rst_valid", 12'(instr_valid), 12'h0);
        chk("rst_jump_en", 12'(jump_en), 12'h0);
        chk("rst_jump_addr", jump_addr, 12'h000);
        chk("rst_halted", 12'(halted), 12'h0);
        @(negedge clk);
        Rst = 0;
        model_reset();
        sys_pc = 0; sys_started = 0;
    endtask

    // One PC step: phase rises at a negedge, sample edge at the next posedge.
    task automatic sample_step(input logic use_rom, input logic [7:0] b, input logic c, input logic z);
        logic [7:0] bv;
        @(negedge clk);
        if (sys_started) sys_pc = jump_en ? jump_addr : sys_pc + 12'd1;
        else sys_started = 1;
        bv = use_rom ? rom[sys_pc] : b;
        prog_byte = bv; flag_c = c; flag_z = z; phase = 1;
        model_step(bv, c, z);
        @(posedge clk);
        #1;
        cmp_model();
        $display("step pc=%h byte=%h c=%b z=%b -> valid=%b instr=%h oprnd=%h jen=%b jaddr=%h halted=%b",
                 sys_pc, bv, c, z, instr_valid, instr, oprnd, jump_en, jump_addr, halted);
    endtask

    // Non-sample clocks with garbage on the inputs: valid drops, all else holds.
    task automatic idle_clks(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            phase = 0;
            prog_byte = 8'($urandom); flag_c = 1'($urandom); flag_z = 1'($urandom);
            @(posedge clk);
            #1;
            chk("idle_valid", 12'(instr_valid), 12'h0);
            chk("idle_instr", 12'(instr), 12'(m_instr));
            chk("idle_oprnd", 12'(oprnd), 12'(m_oprnd));
            chk("idle_jump_en", 12'(jump_en), 12'(m_jen));
            chk("idle_jump_addr", jump_addr, m_jaddr);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // byte fc fz | valid instr oprnd jen jaddr | pc
        vecs[0]  = '{8'h35, 1'b0, 1'b0, 1'b1, 4'h3, 4'h5, 1'b0, 12'h000, 12'h000};
        vecs[1]  = '{8'h72, 1'b0, 1'b0, 1'b1, 4'h7, 4'h2, 1'b0, 12'h000, 12'h001};
        vecs[2]  = '{8'hE1, 1'b0, 1'b0, 1'b0, 4'h7, 4'h2, 1'b0, 12'h000, 12'h002};
        vecs[3]  = '{8'h23, 1'b0, 1'b0, 1'b0, 4'h7, 4'h2, 1'b1, 12'h123, 12'h003};
        vecs[4]  = '{8'hA4, 1'b0, 1'b0, 1'b0, 4'h7, 4'h2, 1'b0, 12'h123, 12'h123};
        vecs[5]  = '{8'h56, 1'b0, 1'b0, 1'b0, 4'h7, 4'h2, 1'b0, 12'h123, 12'h124};
        vecs[6]  = '{8'h19, 1'b0, 1'b0, 1'b1, 4'h1, 4'h9, 1'b0, 12'h123, 12'h125};
        vecs[7]  = '{8'hD0, 1'b0, 1'b0, 1'b0, 4'h1, 4'h9, 1'b0, 12'h123, 12'h126};
        vecs[8]  = '{8'h0F, 1'b0, 1'b0, 1'b0, 4'h1, 4'h9, 1'b1, 12'h00F, 12'h127};
        vecs[9]  = '{8'hD0, 1'b0, 1'b1, 1'b0, 4'h1, 4'h9, 1'b0, 12'h00F, 12'h00F};
        vecs[10] = '{8'h0F, 1'b0, 1'b1, 1'b0, 4'h1, 4'h9, 1'b0, 12'h00F, 12'h010};
        vecs[11] = '{8'h5C, 1'b0, 1'b0, 1'b1, 4'h5, 4'hC, 1'b0, 12'h00F, 12'h011};

        model_reset();
        do_reset();

        for (int i = 0; i < 12; i++) begin
            sample_step(1'b0, vecs[i].b, vecs[i].fc, vecs[i].fz);
            chk("tbl_valid", 12'(instr_valid), 12'(vecs[i].ev));
            chk("tbl_instr", 12'(instr), 12'(vecs[i].ei));
            chk("tbl_oprnd", 12'(oprnd), 12'(vecs[i].eo));
            chk("tbl_jump_en", 12'(jump_en), 12'(vecs[i].ej));
            chk("tbl_jump_addr", jump_addr, vecs[i].ea);
            chk("tbl_pc", sys_pc, vecs[i].ep);
            idle_clks(1);
        end

        // Asynchronous reset while a jump is half assembled.
        sample_step(1'b0, 8'hE7, 1'b0, 1'b0);
        idle_clks(1);
        @(negedge clk);
        #2 Rst = 1;
        #1;
        chk("arst_instr", 12'(instr), 12'h0);
        chk("arst_oprnd", 12'(oprnd), 12'h0);
        chk("arst_jump_en", 12'(jump_en), 12'h0);
        chk("arst_jump_addr", jump_addr, 12'h000);
        @(negedge clk);
        Rst = 0;
        model_reset();
        sys_pc = 0; sys_started = 0;
        sample_step(1'b0, 8'h42, 1'b0, 1'b0);
        chk("post_rst_valid", 12'(instr_valid), 12'h1);
        chk("post_rst_instr", 12'(instr), 12'h4);
        chk("post_rst_oprnd", 12'(oprnd), 12'h2);
        chk("post_rst_jump_en", 12'(jump_en), 12'h0);
        idle_clks(1);

        // Phase stuck low in the middle of a jump: nothing moves.
        sample_step(1'b0, 8'hE5, 1'b0, 1'b0);
        idle_clks(10);
        sample_step(1'b0, 8'h67, 1'b0, 1'b0);
        chk("stuck_jump_addr", jump_addr, 12'h567);
        chk("stuck_jump_en", 12'(jump_en), 12'h1);
        idle_clks(1);

`ifdef NIB_FETCH_ILLEGAL_TRAP_EN
        do_reset();
        sample_step(1'b0, 8'h10, 1'b0, 1'b0); idle_clks(1);
        sample_step(1'b0, 8'h20, 1'b0, 1'b0); idle_clks(1);
        sample_step(1'b0, 8'h30, 1'b0, 1'b0); idle_clks(1);
        sample_step(1'b0, 8'hF0, 1'b0, 1'b0);
        chk("trap_halted", 12'(halted), 12'h1);
        chk("trap_jump_en", 12'(jump_en), 12'h1);
        chk("trap_jump_addr", jump_addr, 12'h003);
        chk("trap_valid", 12'(instr_valid), 12'h0);
        idle_clks(1);
        for (int k = 0; k < 6; k++) begin
            sample_step(1'b0, 8'($urandom), 1'($urandom), 1'($urandom));
            chk("halt_hold_addr", jump_addr, 12'h003);
            chk("halt_hold_pc", sys_pc, 12'h003);
            idle_clks(1);
        end
`else
        do_reset();
        sample_step(1'b0, 8'hF3, 1'b0, 1'b0);
        chk("f_op_valid", 12'(instr_valid), 12'h1);
        chk("f_op_instr", 12'(instr), 12'hF);
        chk("f_op_halted", 12'(halted), 12'h0);
        idle_clks(1);
`endif

        // Random ROM program, with a jump chain that wraps through 12'hFFF.
        for (int a = 0; a < 4096; a++) begin
            logic [7:0] r;
            r = 8'($urandom);
            if ($urandom_range(0, 3) == 0) r[7:4] = 4'hA + 4'($urandom_range(0, 4));
`ifdef NIB_FETCH_ILLEGAL_TRAP_EN
            if (r[7:4] == 4'hF) r[7:4] = 4'h0;
`endif
            rom[a] = r;
        end
        rom[0] = 8'hEF;
        rom[1] = 8'hFF;
        rom[12'hFFF] = 8'hE0;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            sample_step(1'b1, 8'h00, 1'b0, 1'b0);
            idle_clks(1);
        end
        chk("wrap_jump_addr", jump_addr, 12'h0EF);
        sample_step(1'b1, 8'h00, 1'b0, 1'b0);
        chk("wrap_pc", sys_pc, 12'h0EF);
        idle_clks(1);

        for (int k = 0; k < 400; k++) begin
            sample_step(1'b1, 8'h00, 1'($urandom), 1'($urandom));
            idle_clks($urandom_range(1, 3));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/nib_fetch.md
Name: nib_fetch

Overview:
- Instruction fetch/decode front end for the nibble processor; sits between program ROM and the program counter.
- Consumes the PC's `phase` and the combinational ROM byte at the current address.
- Splits each byte into opcode and operand nibbles; assembles two-byte jump targets.
- Evaluates jump conditions and drives the PC load interface (`jump_en` / `jump_addr`).

Parameters:
- JC_OP, 4'hA, opcode: jump if carry set
- JNC_OP, 4'hB, opcode: jump if carry clear
- JZ_OP, 4'hC, opcode: jump if zero set
- JNZ_OP, 4'hD, opcode: jump if zero clear
- JMP_OP, 4'hE, opcode: unconditional jump

Ports:
- clk  in  1  system clock
- Rst  in  1  reset, asynchronous, active-high
- phase  in  1  PC phase; PC advances addr on posedge phase
- prog_byte  in  8  ROM data at current PC addr; [7:4] opcode, [3:0] operand
- flag_c  in  1  ALU carry flag
- flag_z  in  1  ALU zero flag
- instr  out  4  decoded opcode of last non-jump instruction
- oprnd  out  4  operand of last non-jump instruction
- instr_valid  out  1  one-clk pulse: instr/oprnd newly updated
- jump_en  out  1  to PC enable; load jump_addr at next posedge phase
- jump_addr  out  12  to PC newaddr
- halted  out  1  illegal-opcode halt indicator (see Optional Feature)

Behaviour:
- Reset is asynchronous and active-high, on Rst; the clock is clk.
- Reset values: state=FETCH, instr=0, oprnd=0, instr_valid=0, jump_en=0, jump_addr=12'h000, halted=0, internal hi-nibble register=0.
- Sample edge = posedge clk with phase==1.
  - PC's addr changed at the preceding posedge phase, so prog_byte is settled.
  - All state, instr, oprnd, jump_en and jump_addr updates happen only on sample edges.
  - This holds jump_en/jump_addr stable for a full PC step.
- Non-sample edges:
  - instr_valid is forced to 0.
  - Everything else holds.
- State FETCH, on a sample edge:
  - Default for this edge: jump_en <= 0.
  - If prog_byte[7:4] is one of the five jump opcodes:
    - latch hi <= prog_byte[3:0] and the opcode;
    - go to JUMP_LO;
    - instr, oprnd and instr_valid are unchanged.
  - Otherwise:
    - instr <= prog_byte[7:4], oprnd <= prog_byte[3:0];
    - instr_valid pulses 1 for exactly the following clk;
    - stay in FETCH.
- State JUMP_LO, on a sample edge:
  - target = {hi, prog_byte[7:0]}.
  - Condition is evaluated with flag_c/flag_z sampled at this same edge.
  - Taken: jump_en <= 1, jump_addr <= target.
  - Not taken: jump_en <= 0; jump_addr is unchanged.
  - Next state is FETCH.
  - No instr_valid pulse in either case.
- Latency and PC interaction:
  - Hi byte at address N, lo byte at N+1.
  - jump_en is set at the N+1 sample edge; the next posedge phase loads the target instead of N+2.
  - No flush or bubble is needed.
- A taken jump whose target is itself a jump byte is decoded normally on the next step.
- jump_en is cleared on the first sample edge after it was set, so it is high for exactly one PC step.
- A jump at address 12'hFFF takes its lo byte from 12'h000, following PC wrap; no special case.
- Rst asserted mid-sequence, including in JUMP_LO: immediate return to reset values. A half-assembled jump is discarded.
- phase stuck at 0: no sample edges; block holds all state.

Optional Feature:
- Macro: NIB_FETCH_ILLEGAL_TRAP_EN.
- Defined:
  - Opcode 4'hF in FETCH enters state HALT, with halted <= 1 and jump_en <= 1, jump_addr <= PC address of the 4'hF byte.
    - That address is tracked by an internal 12-bit shadow counter: reset 0, +1 per sample edge, loaded with the target on a taken jump.
  - In HALT: jump_en stays 1 and jump_addr is held, so the PC spins on that address.
  - instr_valid never pulses; only Rst exits HALT.
- Undefined:
  - 4'hF decodes as an ordinary instruction.
  - halted is tied 0; no HALT state and no shadow counter exist.

Test Plan:
- Reset, then bytes 8'h35, 8'h72 at consecutive steps -> instr/oprnd = 3/5 then 7/2; one instr_valid pulse each; jump_en stays 0.
- Bytes 8'hE1, 8'h23 (JMP) -> no instr_valid; jump_en=1, jump_addr=12'h123 for one PC step; next sampled addr is 12'h123.
- JC with flag_c=0 (bytes 8'hA4, 8'h56) -> jump_en stays 0; the following byte 8'h19 yields instr=1, oprnd=9.
- JNZ with flag_z=0 (bytes 8'hD0, 8'h0F) -> jump_en=1, jump_addr=12'h00F; repeat with flag_z=1 -> not taken.
- Assert Rst while in JUMP_LO after byte 8'hE7 -> all outputs 0 and state FETCH; the next byte 8'h42 decodes as instr=4, oprnd=2.
- With NIB_FETCH_ILLEGAL_TRAP_EN, byte 8'hF0 at addr 12'h003 -> halted=1, jump_en=1, jump_addr=12'h003 held indefinitely until Rst.
